bram_sp_port_ctrl: RTL and testbench

//  Initiator-side controller for a single-port read-first block RAM (en/we/addr/di -> registered dout).

---
 rtl/bram_ctrl_pkg.sv | 14 +
 rtl/bram_rsp_fifo.sv | 49 ++++
 rtl/bram_sp_port_ctrl.sv | 123 ++++++++++++
 tb/tb_bram_sp_port_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared types for the single-port BRAM controller.
//   state_t   : controller FSM states (reset hold, zero-fill, run)
//   RSP_DEPTH : read response buffer depth
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Two-entry synchronous FIFO holding read data on its way to the consumer.
//   clk, rst_n : clock, async active-low reset (clears contents and pointers)
//   push, din  : write one entry (never issued when full)
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry, held stable until popped
//   occ        : number of stored entries, 0..2
module bram_rsp_fifo
  import bram_ctrl_pkg::*;
#(
  parameter int D = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] dout,
  output logic [1:0]   occ
);

  logic [RSP_DEPTH-1:0][D-1:0] mem;
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic                        pop_ok;

  assign pop_ok = pop && (occ != 2'd0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/bram_sp_port_ctrl.sv
// Initiator-side controller for a single-port read-first block RAM.
// Sequences valid/ready read/write requests onto the RAM port (one access
// per cycle) and returns read data in order through a 2-entry buffer.
// Optionally zero-fills the whole RAM after reset before taking traffic.
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/ready, req_we/addr/wdata : request channel
//   rsp_valid/ready, rsp_rdata         : read response channel
//   init_done                          : high once in RUN
//   ram_en/we/addr/di, ram_dout        : RAM port (dout one cycle after read)
module bram_sp_port_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int D       = 18,
  parameter int A       = 10,
  parameter int INIT_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [A-1:0] req_addr,
  input  logic [D-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [D-1:0] rsp_rdata,
  output logic         init_done,
  output logic         ram_en,
  output logic         ram_we,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_di,
  input  logic [D-1:0] ram_dout
);

  state_t       state;
  logic [A:0]   init_cnt;
  logic [A:0]   cnt_nxt;
  logic         rd_inflight;
  logic [1:0]   occ;
  logic         fire;
  logic         pop;

  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (occ != 2'd0);

  // Accept only if the buffer can absorb everything already committed:
  // occ + rd_inflight - pop < 2, rearranged to avoid an unsigned underflow.
  // Writes obey the same rule so req_ready never depends on req_we.
  assign req_ready = (state == ST_RUN) &&
                     (({1'b0, occ} + {2'b00, rd_inflight}) < (3'd2 + {2'b00, pop}));
  assign fire      = req_valid && req_ready;

  // Counter MSB flags the step past the last address.
  assign cnt_nxt = init_cnt + {{A{1'b0}}, 1'b1};

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    case (state)
      ST_INIT: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = init_cnt[A-1:0];
      end
      ST_RUN: begin
        ram_en   = fire;
        ram_we   = fire && req_we;
        ram_addr = req_addr;
        ram_di   = req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          if (INIT_EN != 0) begin
            state <= ST_INIT;
          end else begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_INIT: begin
          if (cnt_nxt[A]) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
            init_cnt  <= '0;
          end else begin
            init_cnt <= cnt_nxt;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_RST;
      endcase
    end
  end

  // RAM dout is valid the cycle after a read is issued; push it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_inflight <= 1'b0;
    else        rd_inflight <= fire && !req_we;
  end

  bram_rsp_fifo #(.D(D)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_inflight),
    .pop   (pop),
    .din   (ram_dout),
    .dout  (rsp_rdata),
    .occ   (occ)
  );

endmodule

// File: tb/tb_bram_sp_port_ctrl.sv
// Directed bench: one controller with zero-fill (u_dut) and one without
// (u_dut_n), each driving its own read-first RAM model.
module tb_bram_sp_port_ctrl;

  localparam int D = 18;
  localparam int A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done;
  logic [A-1:0] req_addr, ram_addr;
  logic [D-1:0] req_wdata, rsp_rdata, ram_di, ram_dout;
  logic         ram_en, ram_we;

  logic         n_rst_n, n_req_valid, n_req_ready, n_req_we, n_rsp_valid, n_rsp_ready, n_init_done;
  logic [A-1:0] n_req_addr, n_ram_addr;
  logic [D-1:0] n_req_wdata, n_rsp_rdata, n_ram_di, n_ram_dout;
  logic         n_ram_en, n_ram_we;

  logic [D-1:0] mem   [2**A];
  logic [D-1:0] n_mem [2**A];

  int n_cmp = 0;
  int n_bad = 0;

  bram_sp_port_ctrl #(.D(D), .A(A), .INIT_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
  );

  bram_sp_port_ctrl #(.D(D), .A(A), .INIT_EN(0)) u_dut_n (
    .clk(clk), .rst_n(n_rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_we(n_req_we), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_rdata(n_rsp_rdata),
    .init_done(n_init_done), .ram_en(n_ram_en), .ram_we(n_ram_we),
    .ram_addr(n_ram_addr), .ram_di(n_ram_di), .ram_dout(n_ram_dout)
  );

  // Read-first single-port RAM models
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_dout <= mem[ram_addr];
    end
    if (n_ram_en) begin
      if (n_ram_we) n_mem[n_ram_addr] <= n_ram_di;
      n_ram_dout <= n_mem[n_ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [D-1:0] vals [1:4];

  initial begin
    vals[1] = 18'h00111; vals[2] = 18'h3FFFF; vals[3] = 18'h15555; vals[4] = 18'h2AAAA;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    n_rst_n = 1'b0; n_req_valid = 1'b0; n_req_we = 1'b0; n_req_addr = '0; n_req_wdata = '0;
    n_rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_port", {ram_en, ram_we, ram_addr, ram_di}, 0);
    repeat (2) @(negedge clk);

    // 1: zero-fill, 16 writes at addresses 0..15
    rst_n = 1'b1;
    #1 chk("t1_pre_init_en", ram_en, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      chk("t1_init_we", {ram_en, ram_we}, 2'b11);
      chk("t1_init_addr", ram_addr, i);
      chk("t1_init_di", ram_di, 0);
      chk("t1_init_ready", req_ready, 0);
    end
    @(negedge clk); #1;
    chk("t1_no_extra_write", ram_en, 0);
    chk("t1_init_done", init_done, 1);
    chk("t1_req_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    #1 chk("t1_rd_en", {ram_en, ram_we}, 2'b10);
    @(negedge clk); req_valid = 1'b0;
    #1 chk("t1_rsp_not_yet", rsp_valid, 0);
    @(negedge clk); #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_zero", rsp_rdata, 0);

    // 2: write then read-back of the same address
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 18'h2A5A5;
    #1 chk("t2_wr_port", {ram_en, ram_we, ram_addr, ram_di}, {2'b11, 4'd5, 18'h2A5A5});
    @(negedge clk); req_we = 1'b0;
    #1 chk("t2_rd_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    #1 chk("t2_rsp_not_yet", rsp_valid, 0);
    @(negedge clk); #1;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_data", rsp_rdata, 18'h2A5A5);

    // 3: four back-to-back reads, responses on consecutive cycles
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(k); req_wdata = vals[k];
    end
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i + 1);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (i < 4) chk("t3_ready", req_ready, 1);
      if (i >= 2 && i <= 5) begin
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_data", rsp_rdata, vals[i - 1]);
      end else if (i != 0) begin
        chk("t3_rsp_idle", rsp_valid, 0);
      end
    end

    // 4: consumer stalled, exactly two reads accepted, then drain
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    #1 chk("t4_acc1", req_ready, 1);
    @(negedge clk); req_addr = 4'd3;
    #1 chk("t4_acc2", req_ready, 1);
    @(negedge clk); req_addr = 4'd4;
    #1;
    chk("t4_blocked", req_ready, 0);
    chk("t4_head", rsp_rdata, vals[2]);
    @(negedge clk); #1;
    chk("t4_still_blocked", req_ready, 0);
    chk("t4_held_valid", rsp_valid, 1);
    chk("t4_held_data", rsp_rdata, vals[2]);
    rsp_ready = 1'b1;
    #1 chk("t4_ready_on_pop", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    #1 chk("t4_drain2", rsp_rdata, vals[3]);
    @(negedge clk); #1;
    chk("t4_drain3_valid", rsp_valid, 1);
    chk("t4_drain3", rsp_rdata, vals[4]);
    @(negedge clk); #1;
    chk("t4_empty", rsp_valid, 0);

    // 5: reset with data buffered and a read in flight
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    @(negedge clk); req_addr = 4'd2;
    @(negedge clk); req_valid = 1'b0;
    #1 chk("t5_buffered", rsp_rdata, vals[1]);
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_ram_en", ram_en, 0);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_init_done", init_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("t5_init_restart", {ram_we, ram_addr}, {1'b1, 4'd0});
    repeat (16) @(negedge clk);
    #1;
    chk("t5_init_done", init_done, 1);
    chk("t5_no_stale_rsp", rsp_valid, 0);
    req_valid = 1'b1; req_addr = 4'd5;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); #1;
    chk("t5_refill_valid", rsp_valid, 1);
    chk("t5_refill_zero", rsp_rdata, 0);

    // 6: no zero-fill
    @(negedge clk);
    n_rst_n = 1'b1;
    #1;
    chk("t6_pre_done", n_init_done, 0);
    chk("t6_pre_en", n_ram_en, 0);
    @(negedge clk); #1 chk("t6_no_write1", n_ram_en, 0);
    @(negedge clk); #1;
    chk("t6_init_done", n_init_done, 1);
    chk("t6_ready", n_req_ready, 1);
    chk("t6_no_write2", n_ram_en, 0);
    n_req_valid = 1'b1; n_req_we = 1'b1; n_req_addr = 4'd7; n_req_wdata = 18'h1BEEF;
    #1 chk("t6_wr_port", {n_ram_en, n_ram_we, n_ram_addr}, {2'b11, 4'd7});
    @(negedge clk); n_req_we = 1'b0;
    #1 chk("t6_rd_port", {n_ram_en, n_ram_we}, 2'b10);
    @(negedge clk); n_req_valid = 1'b0;
    @(negedge clk); #1;
    chk("t6_rsp_valid", n_rsp_valid, 1);
    chk("t6_rsp_data", n_rsp_rdata, 18'h1BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
